// File: rtl/spi_mmio_bridge.sv
// SPI mode-0 slave (MSB first) that turns command/data frames into single-cycle
// register-bus strobes; SPI pins are oversampled in the clk domain.
module spi_mmio_bridge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          AUTO_INC    = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       spi_sclk_i,
   input  logic       spi_cs_ni,
   input  logic       spi_mosi_i,
   output logic       spi_miso_o,
   output logic       spi_miso_oe_o,
   output logic       bus_cs_o,
   output logic       bus_rd_o,
   output logic       bus_wr_o,
   output logic [7:0] bus_addr_o,
   output logic [7:0] bus_wdata_o,
   input  logic [7:0] bus_rdata_i,
   output logic       frame_active_o,
   output logic       err_abort_o
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CMD      = 3'd1;
   localparam logic [2:0] ST_WR_DATA  = 3'd2;
   localparam logic [2:0] ST_RD_FETCH = 3'd3;
   localparam logic [2:0] ST_RD_DATA  = 3'd4;

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic       sclk_prev_q, cs_prev_q;
   logic       sclk_s, cs_s, mosi_s;
   logic       sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, byte_done_s;
   logic [7:0] rx_next_s;

   logic [2:0] state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [6:0] addr_q, addr_d;
   logic       skip_fall_q, skip_fall_d;
   logic       bus_cs_q, bus_cs_d, bus_rd_q, bus_rd_d, bus_wr_q, bus_wr_d;
   logic [7:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
   logic       frame_active_q, frame_active_d;
   logic       miso_q, miso_d, miso_oe_q, miso_oe_d;
   logic       err_abort_q, err_abort_d;

   function automatic logic [6:0] next_addr(input logic [6:0] a);
      logic [6:0] n;
      if (AUTO_INC && (a != 7'h7F)) begin
         n = a + 7'd1;
      end else begin
         n = a;
      end
      return n;
   endfunction

   // Synchronizers reset to 0 so a frame only opens on a clean cs_n falling edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_ni};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s        = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise_s = sclk_s & ~sclk_prev_q;
   assign sclk_fall_s = ~sclk_s & sclk_prev_q;
   assign cs_rise_s   = cs_s & ~cs_prev_q;
   assign cs_fall_s   = ~cs_s & cs_prev_q;
   assign rx_next_s   = {rx_shift_q[6:0], mosi_s};
   assign byte_done_s = sclk_rise_s && (bit_cnt_q == 3'd7);

   // Frame FSM, shift registers and next values of the registered outputs.
   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      rx_shift_d     = rx_shift_q;
      tx_shift_d     = tx_shift_q;
      addr_d         = addr_q;
      skip_fall_d    = skip_fall_q;
      bus_cs_d       = 1'b0;
      bus_rd_d       = 1'b0;
      bus_wr_d       = 1'b0;
      bus_addr_d     = bus_addr_q;
      bus_wdata_d    = bus_wdata_q;
      frame_active_d = frame_active_q;
      miso_oe_d      = miso_oe_q;
      err_abort_d    = 1'b0;

      if (state_q == ST_IDLE) begin
         if (cs_fall_s) begin
            state_d        = ST_CMD;
            frame_active_d = 1'b1;
            miso_oe_d      = 1'b1;
            bit_cnt_d      = 3'd0;
            rx_shift_d     = 8'h00;
            tx_shift_d     = 8'h00;
            skip_fall_d    = 1'b0;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (cs_rise_s) begin
         // A partial byte is dropped without any bus strobe.
         state_d        = ST_IDLE;
         frame_active_d = 1'b0;
         miso_oe_d      = 1'b0;
         err_abort_d    = (bit_cnt_q != 3'd0);
         bit_cnt_d      = 3'd0;
         rx_shift_d     = 8'h00;
         skip_fall_d    = 1'b0;
      end else begin
         if (sclk_rise_s) begin
            rx_shift_d = rx_next_s;
            bit_cnt_d  = bit_cnt_q + 3'd1;
         end else begin
            rx_shift_d = rx_shift_q;
         end
         // The fall right after a completed byte keeps the freshly fetched MSB on MISO.
         if (sclk_fall_s) begin
            skip_fall_d = 1'b0;
            if ((state_q == ST_RD_DATA) && !skip_fall_q) begin
               tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end else begin
               tx_shift_d = tx_shift_q;
            end
         end else begin
            skip_fall_d = skip_fall_q;
         end
         if (byte_done_s) begin
            skip_fall_d = 1'b1;
         end else begin
            skip_fall_d = skip_fall_d;
         end

         case (state_q)
            ST_CMD: begin
               if (byte_done_s) begin
                  addr_d = rx_next_s[6:0];
                  if (rx_next_s[7]) begin
                     state_d    = ST_RD_FETCH;
                     bus_cs_d   = 1'b1;
                     bus_rd_d   = 1'b1;
                     bus_addr_d = {1'b0, rx_next_s[6:0]};
                  end else begin
                     state_d = ST_WR_DATA;
                  end
               end else begin
                  state_d = ST_CMD;
               end
            end
            ST_WR_DATA: begin
               if (byte_done_s) begin
                  bus_cs_d    = 1'b1;
                  bus_wr_d    = 1'b1;
                  bus_addr_d  = {1'b0, addr_q};
                  bus_wdata_d = rx_next_s;
                  addr_d      = next_addr(addr_q);
               end else begin
                  addr_d = addr_q;
               end
            end
            ST_RD_FETCH: begin
               tx_shift_d = bus_rdata_i;
               addr_d     = next_addr(addr_q);
               state_d    = ST_RD_DATA;
            end
            ST_RD_DATA: begin
               if (byte_done_s) begin
                  state_d    = ST_RD_FETCH;
                  bus_cs_d   = 1'b1;
                  bus_rd_d   = 1'b1;
                  bus_addr_d = {1'b0, addr_q};
               end else begin
                  state_d = ST_RD_DATA;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if ((state_d == ST_RD_FETCH) || (state_d == ST_RD_DATA)) begin
         miso_d = tx_shift_d[7];
      end else begin
         miso_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= 3'd0;
         rx_shift_q     <= 8'h00;
         tx_shift_q     <= 8'h00;
         addr_q         <= 7'h00;
         skip_fall_q    <= 1'b0;
         bus_cs_q       <= 1'b0;
         bus_rd_q       <= 1'b0;
         bus_wr_q       <= 1'b0;
         bus_addr_q     <= 8'h00;
         bus_wdata_q    <= 8'h00;
         frame_active_q <= 1'b0;
         miso_q         <= 1'b0;
         miso_oe_q      <= 1'b0;
         err_abort_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         rx_shift_q     <= rx_shift_d;
         tx_shift_q     <= tx_shift_d;
         addr_q         <= addr_d;
         skip_fall_q    <= skip_fall_d;
         bus_cs_q       <= bus_cs_d;
         bus_rd_q       <= bus_rd_d;
         bus_wr_q       <= bus_wr_d;
         bus_addr_q     <= bus_addr_d;
         bus_wdata_q    <= bus_wdata_d;
         frame_active_q <= frame_active_d;
         miso_q         <= miso_d;
         miso_oe_q      <= miso_oe_d;
         err_abort_q    <= err_abort_d;
      end
   end

   assign spi_miso_o     = miso_q;
   assign spi_miso_oe_o  = miso_oe_q;
   assign bus_cs_o       = bus_cs_q;
   assign bus_rd_o       = bus_rd_q;
   assign bus_wr_o       = bus_wr_q;
   assign bus_addr_o     = bus_addr_q;
   assign bus_wdata_o    = bus_wdata_q;
   assign frame_active_o = frame_active_q;
   assign err_abort_o    = err_abort_q;

endmodule
